frog_game_ctrl: RTL and testbench

//  Game-level sequencer above the frog sprite: owns lives, score and the game state machine.

---
 rtl/frog_game_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_frog_game_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/frog_game_ctrl.sv
// frog_game_ctrl: game-level sequencer for the frog sprite.
// Owns lives, score and the game state machine. Turns the raw direction
// buttons into single-hop requests and drives the frog's animate/dead
// inputs from collision and goal-line events. All state advances only on
// animation strobes; the synchronous reset acts on any clock edge.
module frog_game_ctrl #(
    parameter int LIVES        = 3,
    parameter int GOAL_Y       = 36,
    parameter int DEATH_FRAMES = 60,
    parameter int WIN_FRAMES   = 120
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ani_stb,
    input  logic        i_start_btn,
    input  logic        i_up_btn,
    input  logic        i_down_btn,
    input  logic        i_left_btn,
    input  logic        i_right_btn,
    input  logic        i_hit,
    input  logic [11:0] i_frog_y1,
    output logic        o_animate,
    output logic        o_dead,
    output logic        o_up,
    output logic        o_down,
    output logic        o_left,
    output logic        o_right,
    output logic [3:0]  o_lives,
    output logic [7:0]  o_score,
    output logic [2:0]  o_state
);

    localparam int MAX_FRAMES = (DEATH_FRAMES > WIN_FRAMES) ? DEATH_FRAMES : WIN_FRAMES;
    localparam int TW         = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PLAY     = 3'd1;
    localparam logic [2:0] ST_DYING    = 3'd2;
    localparam logic [2:0] ST_LEVEL_UP = 3'd3;
    localparam logic [2:0] ST_OVER     = 3'd4;

    localparam logic [TW-1:0] DEATH_LAST = TW'(DEATH_FRAMES - 1);
    localparam logic [TW-1:0] WIN_LAST   = TW'(WIN_FRAMES - 1);
    localparam logic [3:0]    LIVES_INIT = 4'(LIVES);
    localparam logic [11:0]   GOAL_ROW   = 12'(GOAL_Y);

    // Button vector order: {start, up, down, left, right}
    logic [4:0]    btn_s;
    logic [4:0]    press_s;
    logic [4:0]    btn_hist_r;

    logic [2:0]    state_r;
    logic [2:0]    state_nxt_s;
    logic [TW-1:0] timer_r;
    logic [TW-1:0] timer_nxt_s;
    logic [3:0]    lives_r;
    logic [3:0]    lives_nxt_s;
    logic [7:0]    score_r;
    logic [7:0]    score_nxt_s;
    logic [3:0]    hop_r;        // {up, down, left, right}
    logic [3:0]    hop_nxt_s;
    logic          animate_r;
    logic          animate_nxt_s;
    logic          dead_r;
    logic          dead_nxt_s;

    assign btn_s   = {i_start_btn, i_up_btn, i_down_btn, i_left_btn, i_right_btn};
    assign press_s = btn_s & ~btn_hist_r;

    // Next-state, counter and hop arbitration logic evaluated for the coming strobe
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = {TW{1'b0}};
        lives_nxt_s = lives_r;
        score_nxt_s = score_r;
        hop_nxt_s   = 4'b0000;
        case (state_r)
            ST_IDLE, ST_OVER: begin
                if (press_s[4]) begin
                    state_nxt_s = ST_PLAY;
                    lives_nxt_s = LIVES_INIT;
                    score_nxt_s = 8'd0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_PLAY: begin
                if (i_hit) begin
                    state_nxt_s = ST_DYING;
                    // PLAY is never reached with zero lives; guard anyway
                    if (lives_r != 4'd0) begin
                        lives_nxt_s = lives_r - 4'd1;
                    end else begin
                        lives_nxt_s = 4'd0;
                    end
                end else if (i_frog_y1 <= GOAL_ROW) begin
                    state_nxt_s = ST_LEVEL_UP;
                    if (score_r != 8'd255) begin
                        score_nxt_s = score_r + 8'd1;
                    end else begin
                        score_nxt_s = score_r;
                    end
                end else begin
                    // Fixed priority: up > down > left > right
                    if (press_s[3]) begin
                        hop_nxt_s = 4'b1000;
                    end else if (press_s[2]) begin
                        hop_nxt_s = 4'b0100;
                    end else if (press_s[1]) begin
                        hop_nxt_s = 4'b0010;
                    end else if (press_s[0]) begin
                        hop_nxt_s = 4'b0001;
                    end else begin
                        hop_nxt_s = 4'b0000;
                    end
                end
            end
            ST_DYING: begin
                if (timer_r == DEATH_LAST) begin
                    if (lives_r == 4'd0) begin
                        state_nxt_s = ST_OVER;
                    end else begin
                        state_nxt_s = ST_PLAY;
                    end
                end else begin
                    timer_nxt_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            ST_LEVEL_UP: begin
                if (timer_r == WIN_LAST) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    timer_nxt_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Frog control outputs follow the state being entered so they line up with o_state
    always_comb begin
        animate_nxt_s = 1'b0;
        dead_nxt_s    = 1'b0;
        case (state_nxt_s)
            ST_PLAY: begin
                animate_nxt_s = 1'b1;
                dead_nxt_s    = 1'b0;
            end
            ST_DYING, ST_LEVEL_UP: begin
                animate_nxt_s = 1'b1;
                dead_nxt_s    = 1'b1;
            end
            default: begin
                animate_nxt_s = 1'b0;
                dead_nxt_s    = 1'b0;
            end
        endcase
    end

    // State and output registers: reset on any edge, otherwise advance once per strobe
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            timer_r    <= {TW{1'b0}};
            lives_r    <= LIVES_INIT;
            score_r    <= 8'd0;
            btn_hist_r <= 5'b00000;
            hop_r      <= 4'b0000;
            animate_r  <= 1'b0;
            dead_r     <= 1'b0;
        end else if (i_ani_stb) begin
            state_r    <= state_nxt_s;
            timer_r    <= timer_nxt_s;
            lives_r    <= lives_nxt_s;
            score_r    <= score_nxt_s;
            btn_hist_r <= btn_s;
            hop_r      <= hop_nxt_s;
            animate_r  <= animate_nxt_s;
            dead_r     <= dead_nxt_s;
        end
    end

    assign o_state   = state_r;
    assign o_lives   = lives_r;
    assign o_score   = score_r;
    assign o_animate = animate_r;
    assign o_dead    = dead_r;
    assign o_up      = hop_r[3];
    assign o_down    = hop_r[2];
    assign o_left    = hop_r[1];
    assign o_right   = hop_r[0];

endmodule

// File: tb/tb_frog_game_ctrl.sv
// tb_frog_game_ctrl: directed-vector bench for frog_game_ctrl with
// hand-computed expectations (LIVES=3, GOAL_Y=36, DEATH=60, WIN=120).
module tb_frog_game_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_ani_stb;
    logic        i_start_btn;
    logic        i_up_btn;
    logic        i_down_btn;
    logic        i_left_btn;
    logic        i_right_btn;
    logic        i_hit;
    logic [11:0] i_frog_y1;
    logic        o_animate;
    logic        o_dead;
    logic        o_up;
    logic        o_down;
    logic        o_left;
    logic        o_right;
    logic [3:0]  o_lives;
    logic [7:0]  o_score;
    logic [2:0]  o_state;

    int n_vec = 0;
    int n_err = 0;
    int n;

    frog_game_ctrl dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_ani_stb   (i_ani_stb),
        .i_start_btn (i_start_btn),
        .i_up_btn    (i_up_btn),
        .i_down_btn  (i_down_btn),
        .i_left_btn  (i_left_btn),
        .i_right_btn (i_right_btn),
        .i_hit       (i_hit),
        .i_frog_y1   (i_frog_y1),
        .o_animate   (o_animate),
        .o_dead      (o_dead),
        .o_up        (o_up),
        .o_down      (o_down),
        .o_left      (o_left),
        .o_right     (o_right),
        .o_lives     (o_lives),
        .o_score     (o_score),
        .o_state     (o_state)
    );

    // Free-running base clock
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Count strobes spent in state st, bounded so a stuck FSM cannot hang the run
    task automatic frames_in(input logic [2:0] st, output int cnt);
        cnt = 0;
        while (o_state == st && cnt < 400) begin
            tick();
            cnt++;
        end
    endtask

    task automatic hops_zero(input string tag);
        chk(tag, {o_up, o_down, o_left, o_right}, 4'b0000);
    endtask

    initial begin
        i_rst_n = 1'b0; i_ani_stb = 1'b1; i_start_btn = 1'b0;
        i_up_btn = 1'b0; i_down_btn = 1'b0; i_left_btn = 1'b0; i_right_btn = 1'b0;
        i_hit = 1'b0; i_frog_y1 = 12'd100;

        // Reset with strobe running
        repeat (3) tick();
        chk("rst_state", o_state, 3'd0);
        chk("rst_lives", o_lives, 4'd3);
        chk("rst_score", o_score, 8'd0);
        chk("rst_anim", o_animate, 1'b0);
        chk("rst_dead", o_dead, 1'b0);
        hops_zero("rst_hops");

        // Start held while strobe is idle: nothing moves
        i_rst_n = 1'b1;
        tick();
        i_ani_stb = 1'b0; i_start_btn = 1'b1;
        repeat (3) tick();
        chk("nostb_state", o_state, 3'd0);
        i_ani_stb = 1'b1;
        tick();
        chk("start_state", o_state, 3'd1);
        chk("start_anim", o_animate, 1'b1);
        chk("start_dead", o_dead, 1'b0);
        chk("start_lives", o_lives, 4'd3);
        i_start_btn = 1'b0;
        tick();

        // Up+left together: up wins once, then held buttons stay silent
        i_up_btn = 1'b1; i_left_btn = 1'b1;
        tick();
        chk("upleft_hops", {o_up, o_down, o_left, o_right}, 4'b1000);
        for (int k = 0; k < 10; k++) begin
            tick();
            hops_zero("held_hops");
        end
        i_up_btn = 1'b0; i_left_btn = 1'b0;
        tick();
        i_right_btn = 1'b1;
        tick();
        chk("right_hop", {o_up, o_down, o_left, o_right}, 4'b0001);
        i_right_btn = 1'b0;
        tick();
        hops_zero("right_release");
        i_down_btn = 1'b1; i_right_btn = 1'b1;
        tick();
        chk("downright_hops", {o_up, o_down, o_left, o_right}, 4'b0100);
        i_down_btn = 1'b0; i_right_btn = 1'b0;
        tick();

        // First hit; hit kept high 3 more strobes must be ignored in DYING
        i_hit = 1'b1;
        tick();
        chk("hit1_state", o_state, 3'd2);
        chk("hit1_lives", o_lives, 4'd2);
        chk("hit1_dead", o_dead, 1'b1);
        chk("hit1_anim", o_animate, 1'b1);
        repeat (3) tick();
        i_hit = 1'b0;
        chk("dying_hit_lives", o_lives, 4'd2);
        frames_in(3'd2, n);
        chk("death_frames", n + 3, 60);
        chk("revive_state", o_state, 3'd1);
        chk("revive_dead", o_dead, 1'b0);

        // Second and third hits lead to game over
        i_hit = 1'b1; tick(); i_hit = 1'b0;
        chk("hit2_lives", o_lives, 4'd1);
        frames_in(3'd2, n);
        chk("death2_frames", n, 60);
        i_hit = 1'b1; tick(); i_hit = 1'b0;
        chk("hit3_lives", o_lives, 4'd0);
        chk("hit3_state", o_state, 3'd2);
        frames_in(3'd2, n);
        chk("death3_frames", n, 60);
        chk("over_state", o_state, 3'd4);
        chk("over_lives", o_lives, 4'd0);
        chk("over_anim", o_animate, 1'b0);
        chk("over_dead", o_dead, 1'b0);
        repeat (5) tick();
        chk("over_hold", o_state, 3'd4);
        i_start_btn = 1'b1; tick(); i_start_btn = 1'b0;
        chk("restart_state", o_state, 3'd1);
        chk("restart_lives", o_lives, 4'd3);
        chk("restart_score", o_score, 8'd0);

        // Hit and goal on the same strobe: hit wins
        i_frog_y1 = 12'd30; i_hit = 1'b1;
        tick();
        i_frog_y1 = 12'd100; i_hit = 1'b0;
        chk("both_state", o_state, 3'd2);
        chk("both_score", o_score, 8'd0);
        chk("both_lives", o_lives, 4'd2);
        frames_in(3'd2, n);

        // Goal row boundary: 37 stays in PLAY, 30 and 36 score
        i_frog_y1 = 12'd37; tick();
        chk("y37_state", o_state, 3'd1);
        i_frog_y1 = 12'd30; tick(); i_frog_y1 = 12'd100;
        chk("goal_state", o_state, 3'd3);
        chk("goal_score", o_score, 8'd1);
        chk("goal_lives", o_lives, 4'd2);
        chk("goal_dead", o_dead, 1'b1);
        frames_in(3'd3, n);
        chk("win_frames", n, 120);
        chk("win_back", o_state, 3'd1);
        i_frog_y1 = 12'd36; tick(); i_frog_y1 = 12'd100;
        chk("y36_score", o_score, 8'd2);
        frames_in(3'd3, n);

        // Drive the score to saturation
        for (int g = 0; g < 253; g++) begin
            i_frog_y1 = 12'd30; tick(); i_frog_y1 = 12'd100;
            frames_in(3'd3, n);
        end
        chk("score_255", o_score, 8'd255);
        i_frog_y1 = 12'd30; tick(); i_frog_y1 = 12'd100;
        chk("sat_state", o_state, 3'd3);
        chk("sat_score", o_score, 8'd255);
        frames_in(3'd3, n);

        // Reset in the middle of DYING, with the strobe low
        i_hit = 1'b1; tick(); i_hit = 1'b0;
        chk("pre_rst_lives", o_lives, 4'd1);
        repeat (5) tick();
        i_rst_n = 1'b0; i_ani_stb = 1'b0;
        tick();
        chk("mid_rst_state", o_state, 3'd0);
        chk("mid_rst_lives", o_lives, 4'd3);
        chk("mid_rst_score", o_score, 8'd0);
        chk("mid_rst_dead", o_dead, 1'b0);
        chk("mid_rst_anim", o_animate, 1'b0);
        i_rst_n = 1'b1; i_ani_stb = 1'b1;
        i_start_btn = 1'b1; tick(); i_start_btn = 1'b0;
        chk("post_rst_state", o_state, 3'd1);
        chk("post_rst_lives", o_lives, 4'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
